// File: rtl/dsp_mult_arbiter.sv
// dsp_mult_arbiter: round-robin share of one (a*b)+c datapath with in-order result routing; define DSP_MULT_ARBITER_STATS_EN for per-port grant counters
module dsp_mult_arbiter #(
  parameter int WIDTH     = 16,
  parameter int PORTS     = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS*WIDTH-1:0]     s_a_tdata,
  input  logic [PORTS*WIDTH-1:0]     s_b_tdata,
  input  logic [PORTS*WIDTH-1:0]     s_c_tdata,
  input  logic [PORTS-1:0]           s_tvalid,
  output logic [PORTS-1:0]           s_tready,
  output logic [WIDTH-1:0]           m_a_tdata,
  output logic [WIDTH-1:0]           m_b_tdata,
  output logic [WIDTH-1:0]           m_c_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  input  logic [2*WIDTH-1:0]         r_tdata,
  input  logic                       r_tvalid,
  output logic                       r_tready,
  output logic [2*WIDTH-1:0]         o_tdata,
  output logic [$clog2(PORTS)-1:0]   o_tdest,
  output logic                       o_tvalid,
  input  logic                       o_tready,
`ifdef DSP_MULT_ARBITER_STATS_EN
  output logic [PORTS*16-1:0]        grant_cnt,
`endif
  output logic                       err_orphan
);
  localparam int TW = $clog2(PORTS);
  localparam int AW = $clog2(TAG_DEPTH);
  logic [TW-1:0] ptr, win, idx;
  logic [TW:0] sum;
  logic found, grant, full, empty, pop;
  logic [AW:0] wp, rp;
  logic [TW-1:0] tags [TAG_DEPTH];
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < PORTS; k++) begin
      sum = {1'b0, ptr} + (TW+1)'(k);
      idx = TW'(sum >= (TW+1)'(PORTS) ? sum - (TW+1)'(PORTS) : sum);
      if (!found && s_tvalid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign grant = found & (!m_tvalid | m_tready) & !full & rst_n;
  assign s_tready = grant ? PORTS'(1) << win : '0;
  assign o_tdata = r_tdata;
  assign o_tdest = tags[rp[AW-1:0]];
  assign o_tvalid = r_tvalid & !empty;
  assign r_tready = o_tready & !empty;
  assign pop = r_tvalid & r_tready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_a_tdata <= '0;
      m_b_tdata <= '0;
      m_c_tdata <= '0;
      ptr <= '0;
      wp <= '0;
      rp <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (grant) begin
        m_tvalid <= 1'b1;
        m_a_tdata <= s_a_tdata[win*WIDTH +: WIDTH];
        m_b_tdata <= s_b_tdata[win*WIDTH +: WIDTH];
        m_c_tdata <= s_c_tdata[win*WIDTH +: WIDTH];
        ptr <= win == TW'(PORTS-1) ? '0 : win + 1'b1;
        wp <= wp + 1'b1;
      end else if (m_tready) m_tvalid <= 1'b0;
      if (pop) rp <= rp + 1'b1;
      if (r_tvalid && empty) err_orphan <= 1'b1;
    end
  always_ff @(posedge clk)
    if (grant) tags[wp[AW-1:0]] <= win;
`ifdef DSP_MULT_ARBITER_STATS_EN
  for (genvar i = 0; i < PORTS; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) grant_cnt[i*16 +: 16] <= '0;
      else if (s_tvalid[i] && s_tready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
        grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 1'b1;
  end
`endif
endmodule

// File: tb/tb_dsp_mult_arbiter.sv
// tb_dsp_mult_arbiter: directed bench for dsp_mult_arbiter with a latency-4 multiply-add datapath model
module tb_dsp_mult_arbiter;
  localparam int W = 16, P = 4;
  logic clk = 0, rst_n = 0;
  logic [P*W-1:0] s_a_tdata = '0, s_b_tdata = '0, s_c_tdata = '0;
  logic [P-1:0] s_tvalid = '0, s_tready;
  logic [W-1:0] m_a_tdata, m_b_tdata, m_c_tdata;
  logic m_tvalid, m_tready = 1, r_tvalid, r_tready, o_tvalid, o_tready = 1, err_orphan;
  logic [2*W-1:0] r_tdata, o_tdata;
  logic [1:0] o_tdest;
`ifdef DSP_MULT_ARBITER_STATS_EN
  logic [P*16-1:0] grant_cnt;
`endif
  always #5 clk = ~clk;
  dsp_mult_arbiter #(.WIDTH(W), .PORTS(P), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_a_tdata(s_a_tdata), .s_b_tdata(s_b_tdata), .s_c_tdata(s_c_tdata),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_a_tdata(m_a_tdata), .m_b_tdata(m_b_tdata), .m_c_tdata(m_c_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .o_tdata(o_tdata), .o_tdest(o_tdest), .o_tvalid(o_tvalid), .o_tready(o_tready),
`ifdef DSP_MULT_ARBITER_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .err_orphan(err_orphan)
  );
  typedef struct {logic [31:0] res; int due;} dp_t;
  dp_t dp_q[$];
  int cyc, g_q[$], od_q[$];
  logic [31:0] odata_q[$];
  logic dp_v, orphan_v = 0;
  logic [31:0] dp_d;
  logic signed [31:0] prod;
  int n_checks = 0, n_fail = 0;
  assign r_tvalid = dp_v | orphan_v;
  assign r_tdata = dp_d;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dp_q.delete();
      cyc = 0;
      dp_v <= 1'b0;
      dp_d <= '0;
    end else begin
      for (int i = 0; i < P; i++) if (s_tvalid[i] && s_tready[i]) g_q.push_back(i);
      if (o_tvalid && o_tready) begin
        od_q.push_back(int'(o_tdest));
        odata_q.push_back(o_tdata);
      end
      if (dp_v && r_tready) void'(dp_q.pop_front());
      if (m_tvalid && m_tready) begin
        prod = $signed(m_a_tdata) * $signed(m_b_tdata) + $signed(m_c_tdata);
        dp_q.push_back('{prod, cyc + 3});
      end
      cyc++;
      dp_v <= dp_q.size() > 0 && dp_q[0].due <= cyc;
      dp_d <= dp_q.size() > 0 ? dp_q[0].res : '0;
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    s_tvalid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    g_q.delete();
    od_q.delete();
    odata_q.delete();
  endtask
  task automatic wait_grants(input int n);
    for (int k = 0; k < 40; k++) begin
      if (g_q.size() >= n) break;
      @(negedge clk);
    end
    check("grant_budget", 64'(g_q.size()), 64'(n));
  endtask
  initial begin
    s_tvalid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 64'(s_tready), 0);
    check("rst_m_tvalid", 64'(m_tvalid), 0);
    check("rst_m_a", 64'(m_a_tdata), 0);
    check("rst_o_tvalid", 64'(o_tvalid), 0);
    check("rst_err", 64'(err_orphan), 0);
    do_reset();
    s_a_tdata[2*W +: W] = 16'd3;
    s_b_tdata[2*W +: W] = 16'hFFFC;
    s_c_tdata[2*W +: W] = 16'd5;
    s_tvalid = 4'b0100;
    @(negedge clk);
    check("single_ready", 64'(s_tready), 4'b0100);
    @(posedge clk);
    #1 s_tvalid = '0;
    @(negedge clk);
    check("single_m_valid", 64'(m_tvalid), 1);
    check("single_m_a", 64'(m_a_tdata), 16'd3);
    check("single_m_b", 64'(m_b_tdata), 16'hFFFC);
    check("single_m_c", 64'(m_c_tdata), 16'd5);
    for (int k = 0; k < 20; k++) begin
      if (o_tvalid) break;
      @(negedge clk);
    end
    check("single_o_valid", 64'(o_tvalid), 1);
    check("single_o_data", 64'(o_tdata), 32'hFFFFFFF9);
    check("single_o_dest", 64'(o_tdest), 2);
    do_reset();
    for (int i = 0; i < P; i++) begin
      s_a_tdata[i*W +: W] = W'(i + 1);
      s_b_tdata[i*W +: W] = 16'd10;
      s_c_tdata[i*W +: W] = W'(i);
    end
    s_tvalid = '1;
    wait_grants(8);
    s_tvalid = '0;
    repeat (15) @(negedge clk);
    check("rr_o_count", 64'(od_q.size()), 8);
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", 64'(g_q[k]), 64'(k % 4));
      if (k < od_q.size()) begin
        check("rr_o_dest", 64'(od_q[k]), 64'(k % 4));
        check("rr_o_data", 64'(odata_q[k]), 64'((k % 4 + 1) * 10 + k % 4));
      end
    end
    do_reset();
    m_tready = 0;
    s_tvalid = '1;
    @(negedge clk);
    check("stall_first_ready", 64'(s_tready), 4'b0001);
    @(negedge clk);
    check("stall_m_valid", 64'(m_tvalid), 1);
    check("stall_m_a", 64'(m_a_tdata), 1);
    check("stall_ready0", 64'(s_tready), 0);
    repeat (3) @(negedge clk);
    check("stall_ready_held", 64'(s_tready), 0);
    check("stall_grants", 64'(g_q.size()), 1);
    m_tready = 1;
    #1 check("resume_ready", 64'(s_tready), 4'b0010);
    @(negedge clk);
    s_tvalid = '0;
    check("resume_grant", 64'(g_q.size() > 1 ? g_q[1] : -1), 1);
    check("resume_m_a", 64'(m_a_tdata), 2);
    repeat (15) @(negedge clk);
    check("resume_o_count", 64'(od_q.size()), 2);
    do_reset();
    o_tready = 0;
    s_tvalid = '1;
    wait_grants(8);
    repeat (6) @(negedge clk);
    check("full_grants", 64'(g_q.size()), 8);
    check("full_ready", 64'(s_tready), 0);
    check("full_o_valid", 64'(o_tvalid), 1);
    check("full_o_dest", 64'(o_tdest), 0);
    o_tready = 1;
    #1 check("full_pop_ready", 64'(s_tready), 0);
    @(negedge clk);
    o_tready = 0;
    check("full_o_count", 64'(od_q.size()), 1);
    check("full_free_ready", 64'(s_tready), 4'b0001);
    @(negedge clk);
    check("full_regrant", 64'(g_q.size()), 9);
    s_tvalid = '0;
    o_tready = 1;
    repeat (20) @(negedge clk);
    check("full_drain", 64'(od_q.size()), 9);
    check("full_last_dest", 64'(od_q.size() == 9 ? od_q[8] : -1), 0);
    orphan_v = 1;
    #1 check("orphan_r_ready", 64'(r_tready), 0);
    check("orphan_o_valid", 64'(o_tvalid), 0);
    @(posedge clk);
    #1 orphan_v = 0;
    check("orphan_err", 64'(err_orphan), 1);
    m_tready = 0;
    s_tvalid = 4'b1000;
    @(posedge clk);
    #1 s_tvalid = '1;
    check("pre_rst_m_valid", 64'(m_tvalid), 1);
    check("pre_rst_m_a", 64'(m_a_tdata), 4);
    rst_n = 0;
    #1 check("arst_err", 64'(err_orphan), 0);
    check("arst_m_valid", 64'(m_tvalid), 0);
    check("arst_m_a", 64'(m_a_tdata), 0);
    check("arst_s_ready", 64'(s_tready), 0);
    m_tready = 1;
    do_reset();
    @(negedge clk);
    check("post_rst_err", 64'(err_orphan), 0);
`ifdef DSP_MULT_ARBITER_STATS_EN
    s_tvalid = 4'b0010;
    repeat (70000) @(posedge clk);
    #1 s_tvalid = '0;
    check("cnt_p1_sat", 64'(grant_cnt[16 +: 16]), 16'hFFFF);
    check("cnt_p0", 64'(grant_cnt[0 +: 16]), 0);
    check("cnt_p2", 64'(grant_cnt[32 +: 16]), 0);
    check("cnt_p3", 64'(grant_cnt[48 +: 16]), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
